inst_fetch_ctrl: RTL and testbench
==================================

# inst_fetch_ctrl

Fetch sequencer for the instruction ROM. It owns the program counter, drives the ROM's combinational address input, and registers the returned word into an instruction register for the decoder. It redirects on taken branches through an 8-entry target lookup table and detects the all-ones halt word. It also provides the Start/Done handshake to the top-level test harness.

## Interface
Parameters:
- A, 10: PC / ROM address width
- W, 9: instruction width
- CW, 16: retire-counter width

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  begin execution at StartAddr; sampled in IDLE and DONE only
- StartAddr  in  A  first fetch address
- Stall  in  1  datapath hold; freezes PC, IR, InstValid, counter
- BranchTaken  in  1  redirect request for the instruction currently in IR
- BranchIdx  in  3  LUT index of the branch target
- LutWrEn  in  1  write enable for the target LUT
- LutWrIdx  in  3  LUT write index
- LutWrData  in  A  LUT write data
- InstAddress  out  A  PC, wired to ROM address input
- InstIn  in  W  ROM data; combinational from InstAddress
- Inst  out  W  instruction register
- InstValid  out  1  Inst is a live instruction for decode/execute
- Busy  out  1  state == RUN
- Done  out  1  program halted; held until next Start
- RetireCount  out  CW  instructions retired since last Start

## Operation
- Reset values: InstAddress 0, Inst 0, InstValid 0, Busy 0, Done 0, RetireCount 0, all LUT entries 0, state IDLE.
- FSM states and transitions:
  - IDLE: outputs at reset values. Start=1 loads PC←StartAddr, InstValid←0, RetireCount←0, and moves to RUN.
  - RUN, when Stall=0, evaluate in priority order:
    1. Halt: InstValid=1 and Inst=='1. Go to DONE, Done←1, InstValid←0, PC holds. The word fetched this cycle is discarded. Halt is not counted and any BranchTaken is ignored.
    2. Branch: InstValid=1 and BranchTaken=1. PC←LUT[BranchIdx], Inst←InstIn, InstValid←0 (squash the wrong-path fetch), RetireCount+1.
    3. Normal: PC←PC+1, Inst←InstIn, InstValid←1, RetireCount+1 if InstValid was 1.
  - RUN, when Stall=1: all registers hold. BranchTaken and the halt check are not evaluated.
  - DONE: Done=1, InstValid=0, PC and RetireCount hold. Start=1 behaves as in IDLE and clears Done on the same edge.
- Start is ignored in RUN. BranchTaken is ignored when InstValid=0.
- PC arithmetic is modulo 2^A: 2^A−1 wraps to 0 with no flag.
- RetireCount saturates at 2^CW−1.
- LUT writes are accepted in any state, including during Stall. If a write and a branch read hit the same index on the same edge, the branch uses the old entry; the new value is visible the next cycle.
- Reset_n asserted mid-run returns every output and LUT entry to its reset value immediately, without waiting for Clk.

## Timing
- The ROM is combinational. Inst/InstValid lag InstAddress by exactly one edge.
- After the Start edge (edge 0):
  - InstAddress=StartAddr after edge 0.
  - Inst=ROM[StartAddr] with InstValid=1 after edge 1.
  - One instruction per cycle thereafter, absent Stall.
- A taken branch costs one bubble: after the branch edge, InstValid=0 and InstAddress=target. The target instruction is valid on the following edge.
- Halt reaches DONE one edge after the halt word appears in Inst.
- Latency from Start to the first valid instruction is 2 edges.

## Structure
- Package fetch_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} fetch_state_t
  - localparam HALT_WORD = '1 (width W)
  - LUT_DEPTH = 8
- Sub-module branch_lut: 8×A register file with one synchronous write port and one combinational read port, asynchronous reset to 0.

## Test plan
- Start with StartAddr=5 over a sequential ROM → InstAddress 5,6,7 on successive edges; InstValid=1 with Inst=ROM[5] on the second edge; Busy=1.
- Write LUT[3]=40, then BranchTaken=1 with BranchIdx=3 while Inst=ROM[7] → next InstAddress=40 and InstValid=0 for one cycle; then Inst=ROM[40].
- Place ROM[9]=9'h1FF after 4 valid instructions → Done=1, Busy=0, InstValid=0, InstAddress frozen at 10, RetireCount=4. A subsequent Start clears Done.
- Assert Stall for 3 cycles mid-run, with BranchTaken also asserted → InstAddress, Inst, InstValid and RetireCount are unchanged for all 3 cycles and no redirect occurs.
- StartAddr=1023 → InstAddress goes 1023 then 0.
- Drop Reset_n between clock edges during RUN → outputs go to 0 asynchronously and LUT[3] reads 0. After release, the block stays in IDLE until Start.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    // Sequencer modes: waiting for Start, fetching, halted.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    // Default instruction width and the all-ones word that stops the program.
    localparam int INST_W = 9;
    localparam logic [INST_W-1:0] HALT_WORD = '1;

    // Branch target table geometry.
    localparam int LUT_DEPTH = 8;
    localparam int LUT_IDX_W = $clog2(LUT_DEPTH);

endpackage

// File: rtl/branch_lut.sv
// Branch target table: one synchronous write port, one combinational read
// port. A read on the same edge as a write to that entry sees the old value.
module branch_lut
    import fetch_pkg::*;
#(
    parameter int A = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [LUT_IDX_W-1:0] wr_idx,
    input  logic [A-1:0]         wr_data,
    input  logic [LUT_IDX_W-1:0] rd_idx,
    output logic [A-1:0]         rd_data
);

    logic [A-1:0] entry [LUT_DEPTH];

    generate
        for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_entry
            // Each entry clears on reset and loads when addressed by a write.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry[gi] <= '0;
                end else if (wr_en && (wr_idx == LUT_IDX_W'(gi))) begin
                    entry[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign rd_data = entry[rd_idx];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, registers ROM words into the
// instruction register, redirects through the branch table, stops on the
// all-ones halt word, and counts retired instructions.
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int A  = 10,
    parameter int W  = 9,
    parameter int CW = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic [A-1:0]         StartAddr,
    input  logic                 Stall,
    input  logic                 BranchTaken,
    input  logic [LUT_IDX_W-1:0] BranchIdx,
    input  logic                 LutWrEn,
    input  logic [LUT_IDX_W-1:0] LutWrIdx,
    input  logic [A-1:0]         LutWrData,
    output logic [A-1:0]         InstAddress,
    input  logic [W-1:0]         InstIn,
    output logic [W-1:0]         Inst,
    output logic                 InstValid,
    output logic                 Busy,
    output logic                 Done,
    output logic [CW-1:0]        RetireCount
);

    localparam logic [W-1:0]  HALT      = {W{1'b1}};
    localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

    fetch_state_t  state, state_next;
    logic [A-1:0]  pc, pc_next;
    logic [W-1:0]  inst, inst_next;
    logic          valid, valid_next;
    logic [CW-1:0] count, count_next;
    logic [A-1:0]  branch_target;

    branch_lut #(.A(A)) u_lut (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .wr_en   (LutWrEn),
        .wr_idx  (LutWrIdx),
        .wr_data (LutWrData),
        .rd_idx  (BranchIdx),
        .rd_data (branch_target)
    );

    // State and datapath registers; everything clears immediately on reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            pc    <= '0;
            inst  <= '0;
            valid <= 1'b0;
            count <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            inst  <= inst_next;
            valid <= valid_next;
            count <= count_next;
        end
    end

    // Next-state logic: start in IDLE/DONE; halt > branch > sequential in RUN.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        inst_next  = inst;
        valid_next = valid;
        count_next = count;
        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    state_next = RUN;
                    pc_next    = StartAddr;
                    valid_next = 1'b0;
                    count_next = '0;
                end
            end
            RUN: begin
                if (!Stall) begin
                    if (valid && (inst == HALT)) begin
                        // Halt word is not retired; the word fetched now is dropped.
                        state_next = DONE;
                        valid_next = 1'b0;
                    end else if (valid && BranchTaken) begin
                        // Redirect and squash the wrong-path word being fetched.
                        pc_next    = branch_target;
                        inst_next  = InstIn;
                        valid_next = 1'b0;
                        count_next = (count == COUNT_MAX) ? count : count + CW'(1);
                    end else begin
                        pc_next    = pc + A'(1);
                        inst_next  = InstIn;
                        valid_next = 1'b1;
                        if (valid && (count != COUNT_MAX)) begin
                            count_next = count + CW'(1);
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign InstAddress = pc;
    assign Inst        = inst;
    assign InstValid   = valid;
    assign Busy        = (state == RUN);
    assign Done        = (state == DONE);
    assign RetireCount = count;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed scenarios followed by random stimulus,
// every cycle compared against a cycle-level behavioural model.
module tb_inst_fetch_ctrl;

    localparam int A  = 10;
    localparam int W  = 9;
    localparam int CW = 16;
    localparam int ROM_SIZE = 1 << A;
    localparam int COUNT_MAX = (1 << CW) - 1;
    localparam logic [W-1:0] HALT = 9'h1FF;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [A-1:0]  start_addr;
    logic          stall;
    logic          branch_taken;
    logic [2:0]    branch_idx;
    logic          lut_wr_en;
    logic [2:0]    lut_wr_idx;
    logic [A-1:0]  lut_wr_data;
    logic [A-1:0]  inst_address;
    logic [W-1:0]  inst_in;
    logic [W-1:0]  inst;
    logic          inst_valid;
    logic          busy;
    logic          done;
    logic [CW-1:0] retire_count;

    logic [W-1:0] rom [ROM_SIZE];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 = waiting, 1 = running, 2 = halted.
    int           m_mode;
    int           m_pc;
    logic [W-1:0] m_inst;
    bit           m_valid;
    int           m_count;
    int           m_lut [8];

    always #5 clk = ~clk;

    assign inst_in = rom[inst_address];

    inst_fetch_ctrl #(.A(A), .W(W), .CW(CW)) dut (
        .Clk         (clk),
        .Reset_n     (reset_n),
        .Start       (start),
        .StartAddr   (start_addr),
        .Stall       (stall),
        .BranchTaken (branch_taken),
        .BranchIdx   (branch_idx),
        .LutWrEn     (lut_wr_en),
        .LutWrIdx    (lut_wr_idx),
        .LutWrData   (lut_wr_data),
        .InstAddress (inst_address),
        .InstIn      (inst_in),
        .Inst        (inst),
        .InstValid   (inst_valid),
        .Busy        (busy),
        .Done        (done),
        .RetireCount (retire_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 0;
        m_inst  = '0;
        m_valid = 0;
        m_count = 0;
        for (int i = 0; i < 8; i++) m_lut[i] = 0;
    endtask

    // One clock edge of the specified behaviour, using the inputs as they stand.
    task automatic model_edge();
        logic [W-1:0] fetched;
        int           target;
        fetched = rom[m_pc];
        target  = m_lut[branch_idx];
        if (m_mode != 1) begin
            if (start) begin
                m_mode  = 1;
                m_pc    = int'(start_addr);
                m_valid = 0;
                m_count = 0;
            end
        end else if (!stall) begin
            if (m_valid && m_inst == HALT) begin
                m_mode  = 2;
                m_valid = 0;
            end else if (m_valid && branch_taken) begin
                m_pc    = target;
                m_inst  = fetched;
                m_valid = 0;
                if (m_count < COUNT_MAX) m_count++;
            end else begin
                m_pc   = (m_pc + 1) % ROM_SIZE;
                m_inst = fetched;
                if (m_valid && m_count < COUNT_MAX) m_count++;
                m_valid = 1;
            end
        end
        if (lut_wr_en) m_lut[lut_wr_idx] = int'(lut_wr_data);
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".addr"},  32'(inst_address), 32'(m_pc));
        check_eq({tag, ".valid"}, 32'(inst_valid),   32'(m_valid));
        if (m_valid) check_eq({tag, ".inst"}, 32'(inst), 32'(m_inst));
        check_eq({tag, ".busy"},  32'(busy),         32'(m_mode == 1));
        check_eq({tag, ".done"},  32'(done),         32'(m_mode == 2));
        check_eq({tag, ".count"}, 32'(retire_count), 32'(m_count));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        $display("%-8s t=%0t addr=%0d inst=%0h valid=%0b busy=%0b done=%0b retired=%0d",
                 tag, $time, inst_address, inst, inst_valid, busy, done, retire_count);
    endtask

    task automatic idle_inputs();
        start        = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        lut_wr_en    = 1'b0;
    endtask

    // Plant a halt at the next fetch address so the run stops two edges later.
    task automatic force_halt();
        logic [W-1:0] saved;
        int           at;
        at      = m_pc;
        saved   = rom[at];
        rom[at] = HALT;
        step("halt1");
        step("halt2");
        step("halt3");
        rom[at] = saved;
    endtask

    initial begin
        for (int i = 0; i < ROM_SIZE; i++) rom[i] = W'(i % 511);
        reset_n     = 1'b0;
        start_addr  = '0;
        branch_idx  = '0;
        lut_wr_idx  = '0;
        lut_wr_data = '0;
        idle_inputs();
        model_reset();
        #12;
        check_all("reset");
        check_eq("reset.inst", 32'(inst), 32'd0);
        reset_n = 1'b1;

        // Load LUT[3]=40 while idle, then start at 5.
        lut_wr_en = 1'b1; lut_wr_idx = 3'd3; lut_wr_data = 10'd40;
        step("lutwr");
        idle_inputs();
        start = 1'b1; start_addr = 10'd5;
        step("start");
        start = 1'b0;
        check_eq("start.addr", 32'(inst_address), 32'd5);
        step("run");
        check_eq("first.inst", 32'(inst), 32'(rom[5]));
        check_eq("first.valid", 32'(inst_valid), 32'd1);
        step("run");
        step("run");
        branch_taken = 1'b1; branch_idx = 3'd3;
        step("branch");
        branch_taken = 1'b0;
        check_eq("branch.addr", 32'(inst_address), 32'd40);
        step("target");
        check_eq("target.inst", 32'(inst), 32'(rom[40]));

        // Halt word at 9 after four retired instructions; restart clears Done.
        force_halt();
        rom[9] = HALT;
        start = 1'b1; start_addr = 10'd5;
        step("start");
        start = 1'b0;
        repeat (6) step("tohalt");
        check_eq("halt.addr", 32'(inst_address), 32'd10);
        check_eq("halt.count", 32'(retire_count), 32'd4);
        check_eq("halt.done", 32'(done), 32'd1);
        repeat (2) step("done");
        rom[9] = W'(9);
        start = 1'b1; start_addr = 10'd5;
        step("restart");
        start = 1'b0;
        check_eq("restart.done", 32'(done), 32'd0);
        repeat (4) step("run");

        // Stall with branch request and a LUT write pending: nothing moves.
        stall = 1'b1; branch_taken = 1'b1; branch_idx = 3'd3;
        lut_wr_en = 1'b1; lut_wr_idx = 3'd5; lut_wr_data = 10'd300;
        repeat (3) step("stall");
        idle_inputs();
        step("unstall");

        // PC wraps from 1023 to 0.
        force_halt();
        start = 1'b1; start_addr = 10'd1023;
        step("start");
        start = 1'b0;
        check_eq("wrap.first", 32'(inst_address), 32'd1023);
        step("wrap");
        check_eq("wrap.zero", 32'(inst_address), 32'd0);
        step("run");

        // Branch reads the old entry when a write hits the same index.
        lut_wr_en = 1'b1; lut_wr_idx = 3'd3; lut_wr_data = 10'd77;
        branch_taken = 1'b1; branch_idx = 3'd3;
        step("wrbr");
        idle_inputs();
        check_eq("wrbr.old", 32'(inst_address), 32'd40);
        step("run");
        branch_taken = 1'b1; branch_idx = 3'd3;
        step("wrbr2");
        branch_taken = 1'b0;
        check_eq("wrbr.new", 32'(inst_address), 32'd77);
        step("run");
        step("run");

        // Asynchronous reset between edges, then LUT[3] must read back as 0.
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("areset");
        #2 reset_n = 1'b1;
        repeat (3) step("postrst");
        start = 1'b1; start_addr = 10'd20;
        step("start");
        start = 1'b0;
        step("run");
        step("run");
        branch_taken = 1'b1; branch_idx = 3'd3;
        step("lutclr");
        branch_taken = 1'b0;
        check_eq("lutclr.addr", 32'(inst_address), 32'd0);

        // Random phase over a random ROM with sparse halt words.
        for (int i = 0; i < ROM_SIZE; i++)
            rom[i] = ($urandom_range(0, 39) == 0) ? HALT : W'($urandom_range(0, 510));
        for (int c = 0; c < 600; c++) begin
            start        = ($urandom_range(0, 7) == 0);
            start_addr   = A'($urandom);
            stall        = ($urandom_range(0, 4) == 0);
            branch_taken = ($urandom_range(0, 3) == 0);
            branch_idx   = 3'($urandom);
            lut_wr_en    = ($urandom_range(0, 3) == 0);
            lut_wr_idx   = 3'($urandom);
            lut_wr_data  = A'($urandom);
            step("rand");
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
